// File: rtl/sd_sector_buf.sv
// sd_sector_buf: one-sector cache between the SD single-block reader and the disk controller.
// A tag hit completes from the buffer; a miss refills the buffer from the reader's byte stream.
module sd_sector_buf #(
  parameter int TIMEOUT_CYC  = 1048576,
  parameter int SECTOR_BYTES = 512
) (
  input  logic        SD_clk,
  input  logic        rst_n,
  input  logic        lba_req,
  input  logic [31:0] lba,
  output logic        ready,
  output logic        buf_valid,
  output logic [31:0] cur_lba,
  output logic        hit,
  output logic        done,
  output logic        err,
  input  logic [8:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        read_req,
  output logic [31:0] sec,
  input  logic        rd_idle,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data
);
  localparam int CW = $clog2(SECTOR_BYTES) + 1;
  localparam int AW = $clog2(SECTOR_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [2:0] {IDLE, REQ, FILL, FINISH, ERR} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmr_q;
  logic        ready_q, buf_valid_q, hit_q, done_q, err_q, read_req_q;
  logic [31:0] cur_lba_q, sec_q;
  logic [7:0]  rd_data_q;
  logic [7:0]  mem [SECTOR_BYTES];
  logic        wr_en, tmo;

  // Bytes past a full sector are dropped rather than wrapping over the start.
  assign wr_en = state_q == FILL && byte_valid && cnt_q < CW'(SECTOR_BYTES);
  assign tmo   = tmr_q == TW'(TIMEOUT_CYC - 1);

  assign ready     = ready_q;
  assign buf_valid = buf_valid_q;
  assign cur_lba   = cur_lba_q;
  assign hit       = hit_q;
  assign done      = done_q;
  assign err       = err_q;
  assign read_req  = read_req_q;
  assign sec       = sec_q;
  assign rd_data   = rd_data_q;

  always_ff @(posedge SD_clk)
    if (wr_en) mem[cnt_q[AW-1:0]] <= byte_data;

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      ready_q     <= 1'b1;
      buf_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      read_req_q  <= 1'b0;
      cur_lba_q   <= '0;
      sec_q       <= '0;
      rd_data_q   <= '0;
    end else begin
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
      rd_data_q <= mem[rd_addr];
      case (state_q)
        IDLE:
          if (lba_req && ready_q) begin
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            if (buf_valid_q && lba == cur_lba_q) hit_q <= 1'b1;
            else begin
              buf_valid_q <= 1'b0;
              cur_lba_q   <= lba;
              sec_q       <= lba;
              read_req_q  <= 1'b1;
              cnt_q       <= '0;
              tmr_q       <= '0;
              state_q     <= REQ;
            end
          end else ready_q <= 1'b1;
        REQ, FILL: begin
          tmr_q <= byte_valid ? '0 : tmr_q + 1'b1;
          if (wr_en) cnt_q <= cnt_q + 1'b1;
          if (tmo) begin
            read_req_q  <= 1'b0;
            err_q       <= 1'b1;
            buf_valid_q <= 1'b0;
            state_q     <= ERR;
          end else if (state_q == REQ && !rd_idle) begin
            read_req_q <= 1'b0;
            state_q    <= FILL;
          end else if (state_q == FILL && rd_idle) state_q <= FINISH;
        end
        FINISH: begin
          if (cnt_q == CW'(SECTOR_BYTES)) begin
            buf_valid_q <= 1'b1;
            done_q      <= 1'b1;
          end else err_q <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        ERR:
          if (rd_idle) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_sector_buf.sv
// tb_sd_sector_buf: scoreboard bench; a behavioural reader streams sectors, expected bytes are
// queued as they are sent and popped while the buffer is read back.
module tb_sd_sector_buf;
  logic        clk = 1'b0, rst_n = 1'b0, lba_req = 1'b0, rd_idle = 1'b1, byte_valid = 1'b0;
  logic [31:0] lba = '0;
  logic [8:0]  rd_addr = '0;
  logic [7:0]  byte_data = '0;
  logic        ready, buf_valid, hit, done, err, read_req;
  logic [31:0] cur_lba, sec;
  logic [7:0]  rd_data;
  int          tests = 0, fails = 0;
  logic [7:0]  exp_q[$];

  sd_sector_buf #(.TIMEOUT_CYC(64), .SECTOR_BYTES(512)) dut (
    .SD_clk(clk), .rst_n(rst_n), .lba_req(lba_req), .lba(lba), .ready(ready),
    .buf_valid(buf_valid), .cur_lba(cur_lba), .hit(hit), .done(done), .err(err),
    .rd_addr(rd_addr), .rd_data(rd_data), .read_req(read_req), .sec(sec),
    .rd_idle(rd_idle), .byte_valid(byte_valid), .byte_data(byte_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic request(input logic [31:0] a);
    @(negedge clk);
    lba_req = 1'b1;
    lba     = a;
    @(negedge clk);
    lba_req = 1'b0;
  endtask

  task automatic start_fill(input logic [31:0] a);
    request(a);
    chk("err_clr", err, 0);
    chk("read_req_up", read_req, 1);
    chk("sec", sec, a);
    repeat (2) @(negedge clk);
    chk("read_req_held", read_req, 1);
    rd_idle = 1'b0;
    @(negedge clk);
    chk("read_req_drop", read_req, 0);
  endtask

  task automatic stream(input int n, input int mul, input int add);
    for (int i = 0; i < n; i++) begin
      byte_data  = 8'(i * mul + add);
      byte_valid = 1'b1;
      if (i < 512) exp_q.push_back(byte_data);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic finish_fill(output int nd, output int nh);
    rd_idle = 1'b1;
    nd = 0;
    nh = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
      if (hit) nh++;
    end
  endtask

  task automatic readback();
    for (int a = 0; a < 512; a++) begin
      @(negedge clk);
      rd_addr = 9'(a);
      @(negedge clk);
      if (exp_q.size() == 0) chk("buf_q_empty", exp_q.size(), 512 - a);
      else chk($sformatf("buf[%0d]", a), rd_data, exp_q.pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, nh, n;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_buf_valid", buf_valid, 0);
    chk("rst_read_req", read_req, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_cur_lba", cur_lba, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // miss: 0x00..0xFF twice
    start_fill(32'h10);
    stream(512, 1, 0);
    finish_fill(nd, nh);
    chk("miss_done_cnt", nd, 1);
    chk("miss_hit_cnt", nh, 0);
    chk("miss_buf_valid", buf_valid, 1);
    chk("miss_err", err, 0);
    chk("miss_ready", ready, 1);
    chk("miss_cur_lba", cur_lba, 32'h10);
    readback();

    // hit on the cached LBA
    request(32'h10);
    chk("hit_pulse", hit, 1);
    chk("hit_done", done, 0);
    chk("hit_read_req", read_req, 0);
    @(negedge clk);
    chk("hit_one_cycle", hit, 0);
    chk("hit_ready", ready, 1);
    chk("hit_read_req2", read_req, 0);

    // short sector
    start_fill(32'h20);
    stream(300, 3, 1);
    exp_q.delete();
    finish_fill(nd, nh);
    chk("short_done_cnt", nd, 0);
    chk("short_err", err, 1);
    chk("short_buf_valid", buf_valid, 0);
    chk("short_ready", ready, 1);

    // overrun: bytes past 512 must be dropped
    start_fill(32'h30);
    stream(520, 7, 3);
    finish_fill(nd, nh);
    chk("ovr_done_cnt", nd, 1);
    chk("ovr_buf_valid", buf_valid, 1);
    chk("ovr_err", err, 0);
    readback();

    // timeout: reader never leaves idle
    request(32'h40);
    n = 0;
    while (read_req && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", n, 64);
    chk("tmo_err", err, 1);
    chk("tmo_buf_valid", buf_valid, 0);
    chk("tmo_read_req", read_req, 0);
    @(negedge clk);
    chk("tmo_ready", ready, 1);
    chk("tmo_err_sticky", err, 1);

    // asynchronous reset mid-fill
    start_fill(32'h50);
    stream(100, 5, 9);
    exp_q.delete();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", ready, 1);
    chk("arst_buf_valid", buf_valid, 0);
    chk("arst_cur_lba", cur_lba, 0);
    chk("arst_read_req", read_req, 0);
    chk("arst_sec", sec, 0);
    chk("arst_err", err, 0);
    chk("arst_hit", hit, 0);
    chk("arst_done", done, 0);
    chk("arst_rd_data", rd_data, 0);
    rd_idle = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    start_fill(32'h50);
    stream(512, 11, 5);
    finish_fill(nd, nh);
    chk("rf_done_cnt", nd, 1);
    chk("rf_hit_cnt", nh, 0);
    chk("rf_buf_valid", buf_valid, 1);
    readback();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
